// File: rtl/calc_pkg.sv
// Shared constants and read-state encoding for the calculator operand store and reader.
package calc_pkg;

  localparam int unsigned NDIG    = 4;
  localparam int unsigned DIGW    = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  OP_CODE = 4'b1010;

  typedef enum logic [1:0] {IDLE, SEND, DONE} rd_state_t;

endpackage

// File: rtl/lz_prienc.sv
// Priority encoder: index of the highest nonzero nibble, plus an all-zero flag.
module lz_prienc #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [4*NDIG-1:0] data_i,
  output logic [IDXW-1:0]   idx_o,
  output logic              all_zero_o
);

  always_comb begin
    idx_o      = '0;
    all_zero_o = 1'b1;
    // Ascending scan so the highest nonzero nibble is the last one written.
    for (int i = 0; i < int'(NDIG); i++) begin
      if (data_i[4*i +: 4] != 4'h0) begin
        idx_o      = IDXW'(i);
        all_zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_digit_reader.sv
// Snapshots one BCD operand register and streams its digits MS-first over valid/ready.
module bcd_digit_reader #(
  parameter int unsigned NDIG    = 4,
  parameter bit          SKIP_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            sel,
  input  logic [4*NDIG-1:0] reg1,
  input  logic [4*NDIG-1:0] reg2,
  input  logic            abort,
  output logic [3:0]      digit,
  output logic [1:0]      digit_pos,
  output logic            digit_valid,
  input  logic            digit_ready,
  output logic            busy,
  output logic            done,
  output logic            bcd_err
);

  import calc_pkg::*;

  localparam int unsigned W = DIGW * NDIG;

  rd_state_t      state_q, state_d;
  logic [W-1:0]   snap_q, snap_d;
  logic [1:0]     idx_q, idx_d;
  logic           err_q, err_d;

  logic [W-1:0]   sel_reg;
  logic [1:0]     lz_idx;
  logic           lz_zero;
  logic [1:0]     start_idx;
  logic [DIGW-1:0] cur_dig;

  assign sel_reg = sel ? reg2 : reg1;

  // Encodes the live selected register so the start index is ready at the start edge.
  lz_prienc #(
    .NDIG(NDIG),
    .IDXW(2)
  ) u_lz_prienc (
    .data_i    (sel_reg),
    .idx_o     (lz_idx),
    .all_zero_o(lz_zero)
  );

  assign start_idx = !SKIP_LZ ? 2'(NDIG - 1) : (lz_zero ? 2'd0 : lz_idx);
  assign cur_dig   = snap_q[DIGW*int'(idx_q) +: DIGW];

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          snap_d  = sel_reg;
          idx_d   = start_idx;
          err_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Abort beats a same-cycle handshake: the digit is not delivered.
        if (abort) begin
          state_d = IDLE;
        end else if (digit_ready) begin
          if (cur_dig > BCD_MAX) err_d = 1'b1;
          if (idx_q == 2'd0) state_d = DONE;
          else               idx_d   = idx_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    digit_valid = (state_q == SEND);
    digit       = digit_valid ? cur_dig : 4'h0;
    digit_pos   = digit_valid ? idx_q : 2'd0;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    bcd_err     = err_q;
  end

endmodule

// File: tb/tb_bcd_digit_reader.sv
// Directed bench: digit-stream vector table plus stall, abort and async-reset sequences.
module tb_bcd_digit_reader;

  logic        clk = 1'b0;
  logic        reset_n, start, sel, abort, digit_ready;
  logic [15:0] reg1, reg2;
  logic [3:0]  digit, digit0;
  logic [1:0]  pos, pos0;
  logic        valid, valid0, busy, busy0, done, done0, err, err0;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  bcd_digit_reader #(.NDIG(4), .SKIP_LZ(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sel(sel), .reg1(reg1), .reg2(reg2),
    .abort(abort), .digit(digit), .digit_pos(pos), .digit_valid(valid),
    .digit_ready(digit_ready), .busy(busy), .done(done), .bcd_err(err)
  );

  bcd_digit_reader #(.NDIG(4), .SKIP_LZ(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .sel(sel), .reg1(reg1), .reg2(reg2),
    .abort(abort), .digit(digit0), .digit_pos(pos0), .digit_valid(valid0),
    .digit_ready(digit_ready), .busy(busy0), .done(done0), .bcd_err(err0)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge where the first digit should be valid.
  task automatic pulse_start(input logic s, input logic [15:0] a, input logic [15:0] b);
    sel = s; reg1 = a; reg2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy && !busy0) break;
      @(negedge clk);
    end
    chk("idle_wait", {14'h0, busy, busy0}, 16'h0);
  endtask

  typedef struct {
    logic        sel;
    logic [15:0] r1;
    logic [15:0] r2;
    int          ndig;
    logic [15:0] seq;   // emitted digits, first in [15:12]
    logic        err;
  } vec_t;

  vec_t vecs[5];
  logic prev_err;

  initial begin
    vecs[0] = '{sel: 1'b0, r1: 16'h0305, r2: 16'h7777, ndig: 3, seq: 16'h3050, err: 1'b0};
    vecs[1] = '{sel: 1'b1, r1: 16'h1111, r2: 16'h0000, ndig: 1, seq: 16'h0000, err: 1'b0};
    vecs[2] = '{sel: 1'b0, r1: 16'h12A4, r2: 16'h0000, ndig: 4, seq: 16'h12A4, err: 1'b1};
    vecs[3] = '{sel: 1'b1, r1: 16'h9999, r2: 16'h0042, ndig: 2, seq: 16'h4200, err: 1'b0};
    vecs[4] = '{sel: 1'b0, r1: 16'h9000, r2: 16'h0001, ndig: 4, seq: 16'h9000, err: 1'b0};

    reset_n = 1'b0; start = 1'b0; sel = 1'b0; abort = 1'b0; digit_ready = 1'b1;
    reg1 = 16'h0; reg2 = 16'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", {15'h0, valid}, 16'h0);
    chk("rst_busy",  {15'h0, busy},  16'h0);
    chk("rst_done",  {15'h0, done},  16'h0);
    chk("rst_err",   {15'h0, err},   16'h0);
    chk("rst_digit", {12'h0, digit}, 16'h0);
    chk("rst_pos",   {14'h0, pos},   16'h0);
    reset_n = 1'b1;
    @(negedge clk);
    prev_err = 1'b0;

    for (int v = 0; v < 5; v++) begin
      wait_idle();
      chk("err_sticky", {15'h0, err}, {15'h0, prev_err});
      pulse_start(vecs[v].sel, vecs[v].r1, vecs[v].r2);
      chk("err_clear", {15'h0, err}, 16'h0);
      for (int k = 0; k < vecs[v].ndig; k++) begin
        chk("tbl_valid", {15'h0, valid}, 16'h1);
        chk("tbl_digit", {12'h0, digit}, (vecs[v].seq >> (12 - 4 * k)) & 16'hF);
        chk("tbl_pos",   {14'h0, pos},   16'(vecs[v].ndig - 1 - k));
        @(negedge clk);
      end
      chk("tbl_done",  {15'h0, done},  16'h1);
      chk("tbl_vlow",  {15'h0, valid}, 16'h0);
      chk("tbl_err",   {15'h0, err},   {15'h0, vecs[v].err});
      @(negedge clk);
      chk("tbl_idle",  {15'h0, busy},  16'h0);
      prev_err = vecs[v].err;
    end

    // All-zero operand without leading-zero suppression: four zeros.
    wait_idle();
    pulse_start(1'b1, 16'h1111, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      chk("nolz_valid", {15'h0, valid0}, 16'h1);
      chk("nolz_digit", {12'h0, digit0}, 16'h0);
      chk("nolz_pos",   {14'h0, pos0},   16'(3 - k));
      if (k == 1) chk("lz_one_digit_done", {15'h0, done}, 16'h1);
      @(negedge clk);
    end
    chk("nolz_done", {15'h0, done0}, 16'h1);

    // Stall, snapshot isolation, ignored starts.
    wait_idle();
    digit_ready = 1'b0;
    pulse_start(1'b0, 16'h1234, 16'h0);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", {15'h0, valid}, 16'h1);
      chk("stall_digit", {12'h0, digit}, 16'h1);
      chk("stall_pos",   {14'h0, pos},   16'h3);
      if (c == 2) reg1 = 16'h9999;
      start = (c == 3);
      @(negedge clk);
    end
    start = 1'b0;
    digit_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("stream_digit", {12'h0, digit}, 16'(k + 1));
      chk("stream_pos",   {14'h0, pos},   16'(3 - k));
      @(negedge clk);
    end
    chk("stream_done", {15'h0, done}, 16'h1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ignored", {15'h0, busy}, 16'h0);
    @(negedge clk);
    chk("no_queued_start", {15'h0, busy}, 16'h0);

    // Abort mid-read, abort+start in idle, then a fresh read.
    wait_idle();
    pulse_start(1'b0, 16'h5678, 16'h0);
    chk("ab_first", {12'h0, digit}, 16'h5);
    @(negedge clk);
    chk("ab_second", {12'h0, digit}, 16'h6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_valid", {15'h0, valid}, 16'h0);
    chk("ab_busy",  {15'h0, busy},  16'h0);
    chk("ab_done",  {15'h0, done},  16'h0);
    @(negedge clk);
    chk("ab_done2", {15'h0, done},  16'h0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("ab_start_drop", {15'h0, busy}, 16'h0);
    pulse_start(1'b0, 16'h5678, 16'h0);
    for (int k = 0; k < 4; k++) begin
      chk("re_digit", {12'h0, digit}, 16'(5 + k));
      chk("re_pos",   {14'h0, pos},   16'(3 - k));
      @(negedge clk);
    end
    chk("re_done", {15'h0, done}, 16'h1);

    // Asynchronous reset between edges mid-read.
    wait_idle();
    pulse_start(1'b0, 16'h12A4, 16'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("ar_digit4", {12'h0, digit}, 16'h4);
    chk("ar_err",    {15'h0, err},   16'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", {15'h0, valid}, 16'h0);
    chk("ar_busy",  {15'h0, busy},  16'h0);
    chk("ar_errclr", {15'h0, err},  16'h0);
    chk("ar_dig",   {12'h0, digit}, 16'h0);
    chk("ar_pos",   {14'h0, pos},   16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar_nodone", {15'h0, done}, 16'h0);
    pulse_start(1'b0, 16'h0042, 16'h0);
    chk("post_d1", {12'h0, digit}, 16'h4);
    chk("post_p1", {14'h0, pos},   16'h1);
    @(negedge clk);
    chk("post_d2", {12'h0, digit}, 16'h2);
    chk("post_p2", {14'h0, pos},   16'h0);
    @(negedge clk);
    chk("post_done", {15'h0, done}, 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
